// File: rtl/uart_tx.sv
// UART transmitter draining a registered-read FIFO: one pop per frame, then
// start bit, LSB-first data, optional parity and 1 or 2 stop bits on tx.
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    par_q, par_d;
    logic                    tx_q, tx_d;
    logic                    bit_end;

    function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] d);
        return (^d) ^ PARITY_ODD;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        tx_d       = tx_q;
        fifo_rd_en = 1'b0;
        tx_done    = 1'b0;
        busy       = (state_q != S_IDLE);
        bit_end    = (cnt_q == CNT_LAST);

        // tx_d is loaded on the last cycle of a bit so the registered line
        // changes exactly on the first clock of the following bit.
        if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP})
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                idx_d = '0;
                if (tx_enable && !fifo_empty)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                fifo_rd_en = 1'b1;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                shreg_d = fifo_rd_data;
                par_d   = frame_parity(fifo_rd_data);
                tx_d    = 1'b0;
                cnt_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    tx_d    = shreg_q[0];
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (PARITY_EN) begin
                            tx_d    = par_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_d[0];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    idx_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        tx_done = 1'b1;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three parameterisations share one FIFO model;
// stimulus queues expected frames, a monitor decodes tx cycle by cycle.
module tb_uart_tx;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        logic       has_par;
        logic       par;
        int         nstop;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] act;
    logic [7:0] mem [0:63];
    logic [7:0] rd_data;
    int         pushes = 0;
    int         pops = 0;
    logic       fempty;
    logic [2:0] tx_w, busy_w, done_w, rd_w, en_w, fe_w;
    logic       tx_a, busy_a, done_a, rd_a;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   cyc = 0;
    int   frame_left = 0;
    int   pos = 0;
    int   nb = 0;
    int   frames_done = 0;
    int   rd_cnt = 0;
    logic bits [0:15];
    int   start_cyc [0:31];
    int   end_cyc [0:31];

    always #5 clk = ~clk;

    assign fempty = (pushes == pops);
    assign tx_a   = tx_w[act];
    assign busy_a = busy_w[act];
    assign done_a = done_w[act];
    assign rd_a   = rd_w[act];
    assign en_w[0] = en && (act == 2'd0);
    assign en_w[1] = en && (act == 2'd1);
    assign en_w[2] = en && (act == 2'd2);
    assign fe_w[0] = fempty || (act != 2'd0);
    assign fe_w[1] = fempty || (act != 2'd1);
    assign fe_w[2] = fempty || (act != 2'd2);

    always @(posedge clk) begin
        if (rd_a) begin
            rd_data <= mem[pops[5:0]];
            pops    <= pops + 1;
        end
    end

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1),
              .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .tx_enable(en_w[0]), .fifo_empty(fe_w[0]),
        .fifo_rd_data(rd_data), .fifo_rd_en(rd_w[0]), .tx(tx_w[0]),
        .busy(busy_w[0]), .tx_done(done_w[0]));

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2),
              .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
        .clk(clk), .reset(reset), .tx_enable(en_w[1]), .fifo_empty(fe_w[1]),
        .fifo_rd_data(rd_data), .fifo_rd_en(rd_w[1]), .tx(tx_w[1]),
        .busy(busy_w[1]), .tx_done(done_w[1]));

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1),
              .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
        .clk(clk), .reset(reset), .tx_enable(en_w[2]), .fifo_empty(fe_w[2]),
        .fifo_rd_data(rd_data), .fifo_rd_en(rd_w[2]), .tx(tx_w[2]),
        .busy(busy_w[2]), .tx_done(done_w[2]));

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic fifo_push(input logic [7:0] d);
        mem[pushes[5:0]] = d;
        pushes++;
    endtask

    task automatic exp_push(input logic [7:0] d, input logic hp, input logic p, input int ns);
        exp_t e;
        e.data = d;
        e.has_par = hp;
        e.par = p;
        e.nstop = ns;
        exp_q.push_back(e);
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 400 && frames_done < n; i++)
            @(negedge clk);
        chk("frame_timeout", int'(frames_done >= n), 1);
    endtask

    task automatic idle_check(input int ncyc);
        repeat (ncyc) begin
            @(negedge clk);
            chk("idle_tx", int'(tx_a), 1);
            chk("idle_busy", int'(busy_a), 0);
            chk("idle_rd_en", int'(rd_a), 0);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                frame_left = 0;
            end else begin
                if (rd_a) begin
                    rd_cnt++;
                    chk("pop_while_empty", int'(fempty), 0);
                end
                if (frame_left == 0) begin
                    chk("stray_tx_done", int'(done_a), 0);
                    if (tx_a == 1'b0) begin
                        chk("frame_expected", int'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            nb = 0;
                            bits[nb] = 1'b0; nb++;
                            for (int i = 0; i < 8; i++) begin
                                bits[nb] = e.data[i]; nb++;
                            end
                            if (e.has_par) begin
                                bits[nb] = e.par; nb++;
                            end
                            for (int i = 0; i < e.nstop; i++) begin
                                bits[nb] = 1'b1; nb++;
                            end
                            frame_left = nb * CPB;
                            pos = 0;
                            start_cyc[frames_done[4:0]] = cyc;
                        end
                    end
                end
                if (frame_left > 0) begin
                    chk("tx_bit", int'(tx_a), int'(bits[pos / CPB]));
                    chk("busy_in_frame", int'(busy_a), 1);
                    chk("tx_done", int'(done_a), int'(frame_left == 1));
                    pos++;
                    frame_left--;
                    if (frame_left == 0) begin
                        end_cyc[frames_done[4:0]] = cyc;
                        frames_done++;
                    end
                end
            end
        end
    endtask

    initial begin
        int base;
        int r0;
        reset = 1'b1;
        en    = 1'b0;
        act   = 2'd0;
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        chk("reset_tx", int'(tx_a), 1);
        chk("reset_busy", int'(busy_a), 0);
        chk("reset_rd_en", int'(rd_a), 0);
        chk("reset_tx_done", int'(done_a), 0);
        reset = 1'b0;

        // single frame 8'hA5, no parity, one stop bit
        en = 1'b1;
        @(negedge clk);
        base = frames_done;
        r0 = rd_cnt;
        fifo_push(8'hA5);
        exp_push(8'hA5, 1'b0, 1'b0, 1);
        @(negedge clk);
        chk("lat_rd_en_n1", int'(rd_a), 1);
        @(negedge clk);
        chk("lat_rd_en_n2", int'(rd_a), 0);
        chk("lat_tx_n2", int'(tx_a), 1);
        @(negedge clk);
        chk("lat_tx_n3", int'(tx_a), 0);
        wait_frames(base + 1);
        chk("t2_rd_pulses", rd_cnt - r0, 1);
        chk("t2_frame_len", end_cyc[base] - start_cyc[base] + 1, 40);

        // even parity, two stop bits: A5 has four ones -> parity 0
        act = 2'd1;
        @(negedge clk);
        base = frames_done;
        fifo_push(8'hA5);
        exp_push(8'hA5, 1'b1, 1'b0, 2);
        wait_frames(base + 1);
        chk("t3_even_len", end_cyc[base] - start_cyc[base] + 1, 48);

        // odd parity: 07 has three ones -> parity 0
        act = 2'd2;
        @(negedge clk);
        base = frames_done;
        fifo_push(8'h07);
        exp_push(8'h07, 1'b1, 1'b0, 1);
        wait_frames(base + 1);
        chk("t3_odd_len", end_cyc[base] - start_cyc[base] + 1, 44);

        // back-to-back frames
        act = 2'd0;
        @(negedge clk);
        base = frames_done;
        r0 = rd_cnt;
        fifo_push(8'h01);
        fifo_push(8'h80);
        exp_push(8'h01, 1'b0, 1'b0, 1);
        exp_push(8'h80, 1'b0, 1'b0, 1);
        wait_frames(base + 2);
        chk("t4_rd_pulses", rd_cnt - r0, 2);
        chk("t4_gap", start_cyc[base + 1] - end_cyc[base], 4);
        chk("t4_fifo_empty", int'(fempty), 1);

        // flow control
        en = 1'b0;
        base = frames_done;
        r0 = rd_cnt;
        fifo_push(8'h3C);
        fifo_push(8'h5A);
        idle_check(20);
        en = 1'b1;
        exp_push(8'h3C, 1'b0, 1'b0, 1);
        repeat (12) @(negedge clk);
        chk("t5_busy_mid", int'(busy_a), 1);
        en = 1'b0;
        wait_frames(base + 1);
        idle_check(30);
        chk("t5_one_pop", rd_cnt - r0, 1);
        chk("t5_fifo_kept", int'(fempty), 0);
        en = 1'b1;
        exp_push(8'h5A, 1'b0, 1'b0, 1);
        wait_frames(base + 2);

        // reset in the middle of the data bits
        @(negedge clk);
        base = frames_done;
        fifo_push(8'hA5);
        exp_push(8'hA5, 1'b0, 1'b0, 1);
        repeat (15) @(negedge clk);
        chk("t1_in_frame", int'(busy_a), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t1_async_tx", int'(tx_a), 1);
        chk("t1_async_busy", int'(busy_a), 0);
        chk("t1_async_rd_en", int'(rd_a), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("t1_no_frame_done", frames_done - base, 0);
        chk("t1_word_lost", int'(fempty), 1);
        idle_check(10);
        fifo_push(8'h5A);
        exp_push(8'h5A, 1'b0, 1'b0, 1);
        wait_frames(base + 1);
        chk("t1_after_len", end_cyc[base] - start_cyc[base] + 1, 40);

        // empty FIFO with transmit enabled
        idle_check(100);
        chk("t6_no_pending", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
